// File: rtl/sdram_pkg.sv
// Shared constants and state encoding for blocks that sit on the SDRAM
// controller's single-slot, clkref-paced byte interface.
package sdram_pkg;

  localparam int SDRAM_ADDR_W   = 25;
  localparam int SDRAM_DATA_W   = 8;
  localparam int DEF_CYCLE_LEN  = 8;
  localparam int DEF_DATA_PHASE = 7;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_BUSY_A = 2'd1,
    STATE_BUSY_B = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester ports A/B plus the SDRAM controller slot, bundled for the arbiter.
interface sdram_port_arbiter_if;
  import sdram_pkg::*;

  logic                    a_req;
  logic                    a_we;
  logic [SDRAM_ADDR_W-1:0] a_addr;
  logic [SDRAM_DATA_W-1:0] a_din;
  logic [SDRAM_DATA_W-1:0] a_dout;
  logic                    a_ack;

  logic                    b_req;
  logic                    b_we;
  logic [SDRAM_ADDR_W-1:0] b_addr;
  logic [SDRAM_DATA_W-1:0] b_din;
  logic [SDRAM_DATA_W-1:0] b_dout;
  logic                    b_ack;

  logic [SDRAM_ADDR_W-1:0] ram_addr;
  logic                    ram_we;
  logic [SDRAM_DATA_W-1:0] ram_din;
  logic [SDRAM_DATA_W-1:0] ram_dout;

  // Requesters and the controller's read byte drive the arbiter.
  modport master (
    output a_req, a_we, a_addr, a_din,
    input  a_dout, a_ack,
    output b_req, b_we, b_addr, b_din,
    input  b_dout, b_ack,
    input  ram_addr, ram_we, ram_din,
    output ram_dout
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    output a_dout, a_ack,
    input  b_req, b_we, b_addr, b_din,
    output b_dout, b_ack,
    output ram_addr, ram_we, ram_din,
    input  ram_dout
  );
endinterface

// File: rtl/clkref_phase.sv
// clkref rising-edge detector and saturating slot phase counter; a stalled
// clkref parks the phase at CYCLE_LEN-1 so the slot machine freezes.
module clkref_phase #(
  parameter int CYCLE_LEN = 8,
  parameter int PHASE_W   = $clog2(CYCLE_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clkref,
  output logic               ref_edge,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CYCLE_LEN - 1);

  logic clkref_d;

  assign ref_edge = clkref & ~clkref_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkref_d <= 1'b0;
      phase    <= PHASE_LAST;
    end else begin
      clkref_d <= clkref;
      if (ref_edge)
        phase <= '0;
      else if (phase != PHASE_LAST)
        phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter onto the SDRAM controller slot: A (CPU/video) has priority,
// B (disk DMA) is forced through after STARVE_MAX consecutive losses.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int CYCLE_LEN  = DEF_CYCLE_LEN,
  parameter int DATA_PHASE = DEF_DATA_PHASE,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clkref,
  sdram_port_arbiter_if.slave bus
);

  localparam int PHASE_W  = $clog2(CYCLE_LEN);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic                ref_edge;
  logic [PHASE_W-1:0]  phase;
  logic [STARVE_W-1:0] starve;
  state_t              state;
  state_t              state_nxt;
  logic                grant_a, grant_b, done_a, done_b;

  clkref_phase #(
    .CYCLE_LEN (CYCLE_LEN),
    .PHASE_W   (PHASE_W)
  ) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .clkref   (clkref),
    .ref_edge (ref_edge),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= STATE_IDLE;
    else          state <= state_nxt;
  end

  // A fresh edge always re-arbitrates, even if it cuts a glitched slot short.
  always_comb begin
    state_nxt = state;
    if (ref_edge) begin
      if (grant_b)      state_nxt = STATE_BUSY_B;
      else if (grant_a) state_nxt = STATE_BUSY_A;
      else              state_nxt = STATE_IDLE;
    end else if (done_a || done_b) begin
      state_nxt = STATE_IDLE;
    end
  end

  always_comb begin
    grant_b = ref_edge && bus.b_req &&
              (!bus.a_req || (starve == STARVE_W'(STARVE_MAX)));
    grant_a = ref_edge && bus.a_req && !grant_b;
    done_a  = (state == STATE_BUSY_A) && ((phase == PHASE_W'(DATA_PHASE)) || ref_edge);
    done_b  = (state == STATE_BUSY_B) && ((phase == PHASE_W'(DATA_PHASE)) || ref_edge);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= '0;
    end else if (ref_edge) begin
      if (!bus.b_req || grant_b)
        starve <= '0;
      else if (starve != STARVE_W'(STARVE_MAX))
        starve <= starve + 1'b1;
    end
  end

  // ram_we still describes the slot in flight when done_x is evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ram_addr <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_din  <= '0;
      bus.a_dout   <= '0;
      bus.b_dout   <= '0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
    end else begin
      bus.a_ack <= done_a;
      bus.b_ack <= done_b;
      if (done_a && !bus.ram_we) bus.a_dout <= bus.ram_dout;
      if (done_b && !bus.ram_we) bus.b_dout <= bus.ram_dout;

      if (grant_b) begin
        bus.ram_addr <= bus.b_addr;
        bus.ram_we   <= bus.b_we;
        bus.ram_din  <= bus.b_din;
      end else if (grant_a) begin
        bus.ram_addr <= bus.a_addr;
        bus.ram_we   <= bus.a_we;
        bus.ram_din  <= bus.a_din;
      end else if (ref_edge || done_a || done_b) begin
        bus.ram_we   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: one task per scenario, cycle index k
// counts negedges after the negedge where clkref is raised.
module tb_sdram_port_arbiter;
  import sdram_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clkref = 1'b0;
  int   tests = 0;
  int   fails = 0;

  sdram_port_arbiter_if bus ();

  sdram_port_arbiter #(
    .CYCLE_LEN  (8),
    .DATA_PHASE (7),
    .STARVE_MAX (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clkref  (clkref),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (bus.ram_addr !== 25'd0) begin fails++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr); end
    tests++; if (bus.ram_we !== 1'b0 || bus.ram_din !== 8'd0) begin fails++; $display("FAIL reset_ram_we_din: got we=%b din=%h want 0/00", bus.ram_we, bus.ram_din); end
    tests++; if (bus.a_dout !== 8'd0 || bus.b_dout !== 8'd0) begin fails++; $display("FAIL reset_dout: got a=%h b=%h want 00/00", bus.a_dout, bus.b_dout); end
    tests++; if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got a=%b b=%b want 0/0", bus.a_ack, bus.b_ack); end
    tests++; if (dut.phase !== 3'd7) begin fails++; $display("FAIL reset_phase: got %0d want 7", dut.phase); end
    tests++; if (dut.state !== STATE_IDLE || dut.starve !== 2'd0) begin fails++; $display("FAIL reset_state_starve: got state=%0d starve=%0d want 0/0", dut.state, dut.starve); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_a_read();
    int acks = 0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h0_0400; bus.a_din = 8'hFF;
    bus.ram_dout = 8'h5A;
    clkref = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      clkref = (k < 4);
      if (bus.a_ack === 1'b1) acks++;
      if (k == 1) begin
        tests++; if (bus.ram_addr !== 25'h0_0400 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL a_read_addr: got addr=%h we=%b want 0000400/0", bus.ram_addr, bus.ram_we); end
      end
      if (k == 8) begin
        tests++; if (bus.a_ack !== 1'b0) begin fails++; $display("FAIL a_read_early_ack: got %b want 0 at k=8", bus.a_ack); end
        bus.ram_dout = 8'hA5;
      end
      if (k == 9) begin
        tests++; if (bus.a_ack !== 1'b1 || bus.a_dout !== 8'hA5) begin fails++; $display("FAIL a_read_ack: got ack=%b dout=%h want 1/a5", bus.a_ack, bus.a_dout); end
        bus.a_req = 1'b0;
      end
    end
    tests++; if (acks != 1) begin fails++; $display("FAIL a_read_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_b_write();
    int bad_we = 0;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 25'h1_2345; bus.b_din = 8'h3C;
    clkref = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      clkref = (k < 4);
      if (k <= 8 && (bus.ram_we !== 1'b1 || bus.ram_din !== 8'h3C)) bad_we++;
      if (k == 1) begin
        tests++; if (bus.ram_addr !== 25'h1_2345) begin fails++; $display("FAIL b_write_addr: got %h want 1012345", bus.ram_addr); end
      end
      if (k == 9) begin
        tests++; if (bus.b_ack !== 1'b1 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL b_write_ack: got ack=%b we=%b want 1/0", bus.b_ack, bus.ram_we); end
        tests++; if (bus.b_dout !== 8'h00 || bus.ram_addr !== 25'h1_2345) begin fails++; $display("FAIL b_write_hold: got dout=%h addr=%h want 00/1012345", bus.b_dout, bus.ram_addr); end
        tests++; if (dut.starve !== 2'd0) begin fails++; $display("FAIL b_write_starve: got %0d want 0", dut.starve); end
        bus.b_req = 1'b0;
      end
    end
    tests++; if (bad_we != 0) begin fails++; $display("FAIL b_write_slot_hold: got %0d bad cycles want 0", bad_we); end
  endtask

  task automatic test_glitch();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h0_0040;
    bus.ram_dout = 8'h5A;
    clkref = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      clkref = (k == 1) || (k >= 3 && k < 7);
      if (k == 3) begin
        bus.ram_dout = 8'h99;
        bus.a_req = 1'b0;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 25'h0_0555; bus.b_din = 8'h11;
      end
      if (k == 4) begin
        tests++; if (bus.a_ack !== 1'b1 || bus.a_dout !== 8'h99) begin fails++; $display("FAIL glitch_a_ack: got ack=%b dout=%h want 1/99", bus.a_ack, bus.a_dout); end
        tests++; if (bus.ram_addr !== 25'h0_0555 || bus.ram_we !== 1'b1 || dut.state !== STATE_BUSY_B) begin fails++; $display("FAIL glitch_regrant: got addr=%h we=%b state=%0d want 0000555/1/2", bus.ram_addr, bus.ram_we, dut.state); end
      end
      if (k == 5) begin
        tests++; if (bus.a_ack !== 1'b0) begin fails++; $display("FAIL glitch_a_ack_width: got %b want 0", bus.a_ack); end
      end
      if (k == 12) begin
        tests++; if (bus.b_ack !== 1'b1 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL glitch_b_ack: got ack=%b we=%b want 1/0", bus.b_ack, bus.ram_we); end
        bus.b_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    logic [24:0] exp_addr [5] = '{25'h100, 25'h100, 25'h100, 25'h200, 25'h100};
    bit          exp_b    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  exp_st   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h100;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 25'h200;
    bus.ram_dout = 8'h42;
    clkref = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      clkref = (k < 40) && ((k % 8) < 4);
      if ((k % 8) == 1 && k < 40) begin
        tests++; if (bus.ram_addr !== exp_addr[k/8] || dut.starve !== exp_st[k/8]) begin fails++; $display("FAIL contention_grant%0d: got addr=%h starve=%0d want %h/%0d", k/8, bus.ram_addr, dut.starve, exp_addr[k/8], exp_st[k/8]); end
      end
      if ((k % 8) == 1 && k >= 9) begin
        tests++; if (bus.a_ack !== !exp_b[(k-9)/8] || bus.b_ack !== exp_b[(k-9)/8]) begin fails++; $display("FAIL contention_ack%0d: got a=%b b=%b want b_wins=%b", (k-9)/8, bus.a_ack, bus.b_ack, exp_b[(k-9)/8]); end
      end
      if (k == 41) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
    end
  endtask

  task automatic test_clkref_stop();
    int acks = 0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h0_0777;
    bus.ram_dout = 8'hC3;
    clkref = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.a_ack === 1'b1) acks++;
      if (k == 9) begin
        tests++; if (bus.a_ack !== 1'b1 || bus.a_dout !== 8'hC3) begin fails++; $display("FAIL stop_ack: got ack=%b dout=%h want 1/c3", bus.a_ack, bus.a_dout); end
      end
      if (k == 20) begin
        tests++; if (dut.phase !== 3'd7) begin fails++; $display("FAIL stop_phase_sat: got %0d want 7", dut.phase); end
      end
    end
    tests++; if (acks != 1 || dut.state !== STATE_IDLE || bus.ram_we !== 1'b0) begin fails++; $display("FAIL stop_no_regrant: got acks=%0d state=%0d we=%b want 1/0/0", acks, dut.state, bus.ram_we); end
    bus.a_req = 1'b0;
    clkref = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_slot();
    int acks = 0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 25'h0_0ABC; bus.a_din = 8'h77;
    clkref = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      clkref = (k < 4);
    end
    tests++; if (dut.state !== STATE_BUSY_A || bus.ram_we !== 1'b1 || dut.phase !== 3'd3) begin fails++; $display("FAIL rst_pre: got state=%0d we=%b phase=%0d want 1/1/3", dut.state, bus.ram_we, dut.phase); end
    reset_n = 1'b0;
    #1;
    tests++; if (bus.ram_we !== 1'b0 || dut.state !== STATE_IDLE || bus.ram_addr !== 25'd0) begin fails++; $display("FAIL rst_async: got we=%b state=%0d addr=%h want 0/0/0", bus.ram_we, dut.state, bus.ram_addr); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 7; k <= 12; k++) begin
      @(negedge clk);
      if (bus.a_ack === 1'b1) acks++;
    end
    tests++; if (acks != 0) begin fails++; $display("FAIL rst_no_ack: got %0d acks want 0", acks); end
    bus.a_we = 1'b0; bus.a_addr = 25'h0_0DEF; bus.ram_dout = 8'h3E;
    clkref = 1'b1;
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      clkref = (m < 4);
      if (m == 1) begin
        tests++; if (bus.ram_addr !== 25'h0_0DEF || dut.state !== STATE_BUSY_A) begin fails++; $display("FAIL rst_regrant: got addr=%h state=%0d want 0000def/1", bus.ram_addr, dut.state); end
      end
      if (m == 9) begin
        tests++; if (bus.a_ack !== 1'b1 || bus.a_dout !== 8'h3E) begin fails++; $display("FAIL rst_regrant_ack: got ack=%b dout=%h want 1/3e", bus.a_ack, bus.a_dout); end
        bus.a_req = 1'b0;
      end
    end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_din = '0;
    bus.ram_dout = '0;
    test_reset();
    test_a_read();
    test_b_write();
    test_glitch();
    test_contention();
    test_clkref_stop();
    test_reset_mid_slot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Sits directly upstream of the Apple II SDRAM controller and owns its single-slot, byte-wide request interface.
- The controller runs one access per 14 MHz clkref period, and its address, write-enable and write data must stay stable for that whole period.
- This block arbitrates between two requesters onto that slot: port A is the CPU/video bus and has priority; port B is the disk track loader/DMA.
- It holds the granted request stable for the whole slot, captures the controller's combinational read byte at a fixed phase, and returns it with a one-cycle ack.

Parameters:
- CYCLE_LEN, 8: clk cycles per clkref period (112 MHz / 14 MHz).
- DATA_PHASE, 7: phase at which read data is captured and ack is pulsed; must be less than CYCLE_LEN.
- STARVE_MAX, 3: number of consecutive slots port B may lose before it is forced to win.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- reset_n  in  1  asynchronous, active-low reset.
- clkref  in  1  14 MHz reference; its rising edge marks a slot start.
- a_req  in  1  port A request level.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  25  port A byte address.
- a_din  in  8  port A write data.
- a_dout  out  8  port A read data, registered.
- a_ack  out  1  port A completion pulse, one clk wide.
- b_req, b_we, b_addr, b_din, b_dout, b_ack: identical to the port A signals, for port B.
- ram_addr  out  25  address to the SDRAM controller.
- ram_we  out  1  write enable to the SDRAM controller.
- ram_din  out  8  write data to the SDRAM controller.
- ram_dout  in  8  read byte from the SDRAM controller (combinational there).

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - phase=CYCLE_LEN-1; state=IDLE; starve=0; clkref_d=0.
  - ram_addr=0, ram_we=0, ram_din=0.
  - a_dout=b_dout=0; a_ack=b_ack=0.
- Reset asserted mid-slot aborts the slot; no ack is issued.
- Edge detect: clkref_d registers clkref; edge = clkref & ~clkref_d.
- Phase counter:
  - On edge, phase<=0.
  - Otherwise phase increments, saturating at CYCLE_LEN-1, so a missing clkref freezes the slot machine.
- State machine: IDLE, BUSY_A, BUSY_B.
  - Requests are sampled only on the edge cycle.
  - On edge, grant is decided:
    - B if b_req and (!a_req or starve==STARVE_MAX);
    - else A if a_req;
    - else none.
  - On grant: ram_addr/ram_we/ram_din are loaded from the winner, and state becomes BUSY_A or BUSY_B.
  - With no grant: state=IDLE, ram_we<=0, ram_addr/ram_din hold.
- Starvation counter:
  - On an edge where b_req=1 and A wins, starve increments, saturating at STARVE_MAX.
  - Whenever B is granted, starve<=0.
  - On an edge with b_req=0, starve<=0.
- BUSY_x at phase==DATA_PHASE:
  - For a read, x_dout<=ram_dout.
  - For a write, x_dout holds.
  - x_ack<=1 for exactly one clk.
  - State returns to IDLE and ram_we<=0 in the same cycle; ram_addr holds.
- If an edge arrives while in BUSY before DATA_PHASE (clkref glitch): the current access completes immediately, with capture and ack in that cycle. The new arbitration is still evaluated in the same cycle, and the new grant takes effect.
- Handshake rules:
  - x_req and its address/data must be stable from the edge until ack.
  - A req still high at the next edge after ack is a new access; requesters drop req on ack.
- Latency: ack occurs DATA_PHASE+1 clks after the edge cycle, because outputs are registered.
- Address and data bits pass through unmodified; no width conversion.

Decomposition:
- Shared package sdram_pkg holds:
  - STATE_IDLE/BUSY_A/BUSY_B encodings (2-bit);
  - SDRAM_ADDR_W=25 and SDRAM_DATA_W=8;
  - default CYCLE_LEN/DATA_PHASE constants, shared with the controller.
- One natural sub-module: clkref_phase, containing the edge detector and saturating phase counter and outputting edge and phase. It is reusable by other clkref-synchronous blocks.

Test Plan:
- Single A read: a_req=1, a_we=0, a_addr=25'h0_0400.
  - ram_addr=0x0400 and ram_we=0 from edge+1.
  - Bench drives ram_dout=8'hA5 at phase 7.
  - a_dout=8'hA5 and a_ack pulses once, 8 clks after the edge.
- B write: b_req=1, b_we=1, b_addr=25'h1_2345, b_din=8'h3C.
  - ram_we=1, ram_din=0x3C for phases 0-7.
  - ram_we drops with b_ack; b_dout unchanged.
- Contention: a_req and b_req held high for 5 slots.
  - Grants are A,A,A,B,A (STARVE_MAX=3).
  - starve reads 0 after the B grant.
- clkref stopped after a grant.
  - phase saturates at 7 and the ack still fires once.
  - No further grants until the next rising edge.
- Reset pulse (reset_n=0 for 2 clks) at phase 3 of a BUSY_A write.
  - ram_we=0 immediately, no a_ack, state IDLE.
  - A clean grant occurs on the next edge.
